// File: rtl/serial_mag_comp_ctrl.sv
// serial_mag_comp_ctrl: unsigned magnitude compare, one 2-bit pair per cycle, MSB pair first.
// Operands shift left so the pair under test always sits in the top two bits.
module serial_mag_comp_ctrl #(
   parameter int WIDTH      = 6,
   parameter bit EARLY_EXIT = 1'b1,
   localparam int CW        = $clog2(WIDTH/2+1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   output logic [CW-1:0]    npairs
);
   localparam logic [CW-1:0] LAST = CW'(WIDTH/2-1);
   typedef enum logic {IDLE, COMPARE} state_t;
   state_t state, state_nx;
   logic [WIDTH-1:0] ra, rb;
   logic [1:0] pa, pb;
   logic resolved, ne, fin;
   assign pa = ra[WIDTH-1 -: 2];
   assign pb = rb[WIDTH-1 -: 2];
   assign ne = pa != pb;
   assign busy = state == COMPARE;
   always_comb begin
      state_nx = state;
      fin = 1'b0;
      if (state == IDLE) begin
         if (start) state_nx = COMPARE;
      end else begin
         fin = (EARLY_EXIT && ne) || npairs == LAST;
         if (fin) state_nx = IDLE;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ra <= '0;
         rb <= '0;
         resolved <= 1'b0;
         done <= 1'b0;
         gt <= 1'b0;
         eq <= 1'b0;
         lt <= 1'b0;
         npairs <= '0;
      end else begin
         done <= 1'b0;
         if (state == IDLE && start) begin
            ra <= a;
            rb <= b;
            resolved <= 1'b0;
            gt <= 1'b0;
            eq <= 1'b0;
            lt <= 1'b0;
            npairs <= '0;
         end else if (state == COMPARE) begin
            ra <= ra << 2;
            rb <= rb << 2;
            npairs <= npairs + 1'b1;
            // the first unequal pair decides; later pairs cannot override it
            if (ne && !resolved) begin
               gt <= pa > pb;
               lt <= pa < pb;
               resolved <= 1'b1;
            end
            if (fin) begin
               done <= 1'b1;
               eq <= !(resolved || ne);
            end
         end
      end
   end
endmodule
